// File: rtl/si_header_pkg.sv
// Shared constants, state encoding and sizing helper for the time-tag
// header parser.
package si_header_pkg;

    // Magic words as seen in little-endian byte order on the wire:
    // bytes 14/15 = 0x53/0x49 ("SI"), bytes 16/17 = 0x54/0x54 ("TT").
    localparam logic [15:0] SI_MAGIC   = 16'h4953;
    localparam logic [15:0] TT_MAGIC   = 16'h5454;
    localparam int          HDR_BYTES  = 28;
    localparam int          SEQ_OFFSET = 24;

    typedef enum logic [1:0] {
        HDR    = 2'd0,
        REPLAY = 2'd1,
        PASS   = 2'd2,
        DROP   = 2'd3
    } state_t;

    // Number of bus words needed to carry the whole header.
    function automatic int hdr_words(input int keep_width, input int hdr_bytes = HDR_BYTES);
        return (hdr_bytes + keep_width - 1) / keep_width;
    endfunction

endpackage

// File: rtl/si_header_buffer.sv
// Small store for the header words of the packet under inspection.
// Written in arrival order while the header is validated, read back in
// the same order once the header is known to be good.
module si_header_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 2,
    parameter int IDX_W      = 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [KEEP_WIDTH-1:0] wr_keep,
    input  logic                  wr_last,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [KEEP_WIDTH-1:0] rd_keep,
    output logic                  rd_last
);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [KEEP_WIDTH-1:0] keep_mem [DEPTH];
    logic                  last_mem [DEPTH];

    // Capture each accepted header word with its sideband.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx] <= wr_data;
            keep_mem[wr_idx] <= wr_keep;
            last_mem[wr_idx] <= wr_last;
        end
    end

    assign rd_data = data_mem[rd_idx];
    assign rd_keep = keep_mem[rd_idx];
    assign rd_last = last_mem[rd_idx];

endmodule

// File: rtl/si_header_parser_v2.sv
// Time-tag packet header parser with sequence tracking.
// Header words are held back until the whole header is validated, so an
// invalid packet never leaks a single beat downstream.
// Optional build macro: SI_HEADER_PARSER_V2_STATS_EN adds packet counters.
//
// state  | meaning
// HDR    | collecting and checking header words, input ready
// REPLAY | emitting the buffered header words, input stalled
// PASS   | payload flows straight through until tlast
// DROP   | discarding the rest of a rejected packet
module si_header_parser_v2 import si_header_pkg::*; #(
    parameter int          DATA_WIDTH = 128,
    parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
    parameter logic [15:0] ETHERTYPE  = 16'h809B,
    parameter logic [7:0]  VERSION    = 8'h00,
    parameter int          HDR_BYTES  = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  lost_packet,
    output logic                  invalid_packet,
    output logic [31:0]           lost_count
`ifdef SI_HEADER_PARSER_V2_STATS_EN
    ,
    output logic [31:0]           stat_rx_packets,
    output logic [31:0]           stat_invalid_packets,
    output logic [31:0]           stat_runt_packets
`endif
);

    localparam int HDR_WORDS = hdr_words(KEEP_WIDTH, HDR_BYTES);
    localparam int IDX_W     = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_WORDS - 1);

    if (DATA_WIDTH != 64 && DATA_WIDTH != 128 && DATA_WIDTH != 256) begin : g_bad_width
        $error("si_header_parser_v2: DATA_WIDTH must be 64, 128 or 256");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic               hdr_ok_q, hdr_ok_d, hdr_ok_now, word_ok;
    logic               in_fire, out_fire, buf_wr;
    logic               hdr_done, hdr_bad, runt;
    logic               seq_valid_q;
    logic [31:0]        expected_q, seq_word, seq_diff;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [KEEP_WIDTH-1:0] buf_keep;
    logic               buf_last;

    // Handshake qualifiers depend on state only (plus the peer's ready in PASS),
    // so REPLAY valid never waits on downstream ready.
    assign s_axis_tready = rst && ((state_q == HDR) || (state_q == DROP) ||
                                   ((state_q == PASS) && m_axis_tready));
    assign m_axis_tvalid = (state_q == REPLAY) || ((state_q == PASS) && s_axis_tvalid);
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = m_axis_tvalid && m_axis_tready;

    si_header_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .DEPTH      (HDR_WORDS),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_wr),
        .wr_idx  (wr_idx_q),
        .wr_data (s_axis_tdata),
        .wr_keep (s_axis_tkeep),
        .wr_last (s_axis_tlast),
        .rd_idx  (rd_idx_q),
        .rd_data (buf_data),
        .rd_keep (buf_keep),
        .rd_last (buf_last)
    );

    // Per-word header check and sequence extraction by absolute byte position.
    always_comb begin
        int         pos;
        logic [7:0] cur;
        word_ok  = 1'b1;
        seq_word = '0;
        pos      = 0;
        cur      = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            pos = int'(wr_idx_q) * KEEP_WIDTH + i;
            cur = s_axis_tdata[8*i +: 8];
            if (pos < HDR_BYTES && !s_axis_tkeep[i]) word_ok = 1'b0;
            case (pos)
                12: if (cur != ETHERTYPE[15:8]) word_ok = 1'b0;
                13: if (cur != ETHERTYPE[7:0])  word_ok = 1'b0;
                14: if (cur != SI_MAGIC[7:0])   word_ok = 1'b0;
                15: if (cur != SI_MAGIC[15:8])  word_ok = 1'b0;
                16: if (cur != TT_MAGIC[7:0])   word_ok = 1'b0;
                17: if (cur != TT_MAGIC[15:8])  word_ok = 1'b0;
                18: if (cur != VERSION)         word_ok = 1'b0;
                19: if (cur != 8'h00)           word_ok = 1'b0;
                default: ;
            endcase
            if (pos >= SEQ_OFFSET && pos < SEQ_OFFSET + 4) seq_word[8*(pos-SEQ_OFFSET) +: 8] = cur;
        end
    end

    assign hdr_ok_now = ((wr_idx_q == '0) ? 1'b1 : hdr_ok_q) && word_ok;
    assign seq_diff   = seq_word - expected_q;

    // Next-state logic and output data mux.
    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        hdr_ok_d     = hdr_ok_q;
        buf_wr       = 1'b0;
        hdr_done     = 1'b0;
        hdr_bad      = 1'b0;
        runt         = 1'b0;
        m_axis_tdata = buf_data;
        m_axis_tkeep = buf_keep;
        m_axis_tlast = buf_last;
        case (state_q)
            HDR: begin
                if (in_fire) begin
                    buf_wr   = 1'b1;
                    hdr_ok_d = hdr_ok_now;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                        if (hdr_ok_now) begin
                            hdr_done = 1'b1;
                            state_d  = REPLAY;
                        end else begin
                            hdr_bad = 1'b1;
                            if (!s_axis_tlast) state_d = DROP;
                        end
                    end else if (s_axis_tlast) begin
                        runt     = 1'b1;
                        wr_idx_d = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            REPLAY: begin
                if (out_fire) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = buf_last ? HDR : PASS;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            PASS: begin
                m_axis_tdata = s_axis_tdata;
                m_axis_tkeep = s_axis_tkeep;
                m_axis_tlast = s_axis_tlast;
                if (in_fire && s_axis_tlast) state_d = HDR;
            end
            default: begin
                if (in_fire && s_axis_tlast) state_d = HDR;
            end
        endcase
    end

    // State register and buffer indices.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= HDR;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            hdr_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            hdr_ok_q <= hdr_ok_d;
        end
    end

    // Sequence tracking; backward jumps (diff >= 2^31) flag but are not counted as loss.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seq_valid_q    <= 1'b0;
            expected_q     <= '0;
            lost_packet    <= 1'b0;
            invalid_packet <= 1'b0;
            lost_count     <= '0;
        end else begin
            lost_packet    <= 1'b0;
            invalid_packet <= runt || hdr_bad;
            if (hdr_done) begin
                if (seq_valid_q && (seq_word != expected_q)) begin
                    lost_packet <= 1'b1;
                    if (!seq_diff[31]) lost_count <= lost_count + seq_diff;
                end
                expected_q  <= seq_word + 32'd1;
                seq_valid_q <= 1'b1;
            end
        end
    end

`ifdef SI_HEADER_PARSER_V2_STATS_EN
    // Wrapping packet statistics; runts are counted as invalid too.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_rx_packets      <= '0;
            stat_invalid_packets <= '0;
            stat_runt_packets    <= '0;
        end else begin
            if (hdr_done)        stat_rx_packets      <= stat_rx_packets + 32'd1;
            if (runt || hdr_bad) stat_invalid_packets <= stat_invalid_packets + 32'd1;
            if (runt)            stat_runt_packets    <= stat_runt_packets + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_si_header_parser_v2.sv
`timescale 1ns/1ps
// Bench for si_header_parser_v2: one DUT per datapath width, each driven
// with directed and random packets and checked against a packet-level model.
module tb_si_header_parser_v2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_w
        localparam int DW = 64 << g;
        localparam int KW = DW / 8;
        localparam int HW = (28 + KW - 1) / KW;
        localparam int BW = DW + KW + 1;

        logic          rst;
        logic          s_valid, s_ready, s_last;
        logic          m_valid, m_ready, m_last;
        logic [DW-1:0] s_data, m_data;
        logic [KW-1:0] s_keep, m_keep;
        logic          lost, inv;
        logic [31:0]   lost_cnt;
`ifdef SI_HEADER_PARSER_V2_STATS_EN
        logic [31:0]   st_rx, st_inv, st_runt;
`endif

        si_header_parser_v2 #(.DATA_WIDTH(DW)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .s_axis_tvalid  (s_valid),
            .s_axis_tready  (s_ready),
            .s_axis_tdata   (s_data),
            .s_axis_tlast   (s_last),
            .s_axis_tkeep   (s_keep),
            .m_axis_tvalid  (m_valid),
            .m_axis_tready  (m_ready),
            .m_axis_tdata   (m_data),
            .m_axis_tlast   (m_last),
            .m_axis_tkeep   (m_keep),
            .lost_packet    (lost),
            .invalid_packet (inv),
            .lost_count     (lost_cnt)
`ifdef SI_HEADER_PARSER_V2_STATS_EN
            ,
            .stat_rx_packets      (st_rx),
            .stat_invalid_packets (st_inv),
            .stat_runt_packets    (st_runt)
`endif
        );

        logic [BW-1:0] exp_q[$];
        int            n_lost_seen = 0;
        int            n_inv_seen  = 0;
        logic          stall_prev  = 1'b0;
        logic [BW-1:0] stall_beat  = '0;
        bit            done = 1'b0;
        bit            bp   = 1'b0;

        logic [31:0] exp_seq;
        bit          seq_v;
        logic [31:0] exp_lc;
        int          n_lost_exp, n_inv_exp, n_rx_exp, n_runt_exp;
        int          base_lost, base_inv;

        function automatic string tagw(input string s);
            return $sformatf("w%0d_%s", DW, s);
        endfunction

        // Output monitor: scoreboard pop, hold-while-stalled check, pulse counting.
        always @(negedge clk) begin
            logic [BW-1:0] beat;
            beat = {m_last, m_keep, m_data};
            if (rst) begin
                if (lost) n_lost_seen++;
                if (inv)  n_inv_seen++;
                if (stall_prev) chk(tagw("hold"), {m_valid, beat}, {1'b1, stall_beat});
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) chk(tagw("spurious_beat"), m_valid, 1'b0);
                    else                   chk(tagw("beat"), beat, exp_q.pop_front());
                end
                stall_prev = m_valid && !m_ready;
                stall_beat = beat;
            end else begin
                stall_prev = 1'b0;
            end
        end

        // Downstream ready: always ready unless backpressure is enabled.
        initial begin
            m_ready = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end

        task automatic build(input int len, input logic [31:0] seq, input int corrupt,
                             output logic [7:0] b[$]);
            b = {};
            for (int i = 0; i < len; i++) begin
                b.push_back(8'($urandom));
                case (i)
                    12: b[i] = 8'h80;
                    13: b[i] = 8'h9B;
                    14: b[i] = 8'h53;
                    15: b[i] = 8'h49;
                    16, 17: b[i] = 8'h54;
                    18, 19: b[i] = 8'h00;
                    24: b[i] = seq[7:0];
                    25: b[i] = seq[15:8];
                    26: b[i] = seq[23:16];
                    27: b[i] = seq[31:24];
                    default: ;
                endcase
            end
            case (corrupt)
                1: if (len > 12) b[12] = 8'h08;
                2: if (len > 15) b[15] = 8'h4A;
                3: if (len > 18) b[18] = 8'h01;
                default: ;
            endcase
        endtask

        // Drives up to max_words of a packet; the model is updated only for whole packets.
        task automatic send(input logic [7:0] b[$], input int max_words, input bit lat_chk);
            int            len, nw, cyc;
            bit            ok, acc;
            logic [31:0]   seq, diff;
            logic [DW-1:0] d;
            logic [KW-1:0] k;
            len = b.size();
            nw  = (len + KW - 1) / KW;
            ok  = 1'b0;
            if (max_words >= nw) begin
                if (nw < HW) begin
                    n_inv_exp++;
                    n_runt_exp++;
                end else begin
                    ok = (len >= 28) && b[12] == 8'h80 && b[13] == 8'h9B && b[14] == 8'h53 &&
                         b[15] == 8'h49 && b[16] == 8'h54 && b[17] == 8'h54 &&
                         b[18] == 8'h00 && b[19] == 8'h00;
                    if (!ok) n_inv_exp++;
                    else begin
                        n_rx_exp++;
                        seq = {b[27], b[26], b[25], b[24]};
                        if (seq_v && seq != exp_seq) begin
                            n_lost_exp++;
                            diff = seq - exp_seq;
                            if (diff < 32'h8000_0000) exp_lc = exp_lc + diff;
                        end
                        exp_seq = seq + 32'd1;
                        seq_v   = 1'b1;
                    end
                end
            end
            for (int w = 0; w < nw && w < max_words; w++) begin
                d = '0;
                k = '0;
                for (int i = 0; i < KW; i++) begin
                    if (w * KW + i < len) begin
                        d[8*i +: 8] = b[w*KW + i];
                        k[i] = 1'b1;
                    end
                end
                if (ok) exp_q.push_back({(w == nw - 1), k, d});
                if ($urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                s_valid = 1'b1;
                s_data  = d;
                s_keep  = k;
                s_last  = (w == nw - 1);
                acc = 1'b0;
                cyc = 0;
                while (!acc && cyc < 500) begin
                    @(negedge clk);
                    acc = s_ready;
                    cyc++;
                    @(posedge clk);
                    #1;
                end
                if (!acc) chk(tagw("accept_timeout"), acc, 1'b1);
                if (lat_chk && ok && w == HW - 1) chk(tagw("first_out_latency"), m_valid, 1'b1);
            end
            s_valid = 1'b0;
        endtask

        task automatic drain();
            int cyc;
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 3000) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            chk(tagw("beats_missing"), exp_q.size(), 0);
            repeat (4) @(posedge clk);
            #1;
            chk(tagw("lost_pulses"), n_lost_seen - base_lost, n_lost_exp);
            chk(tagw("invalid_pulses"), n_inv_seen - base_inv, n_inv_exp);
            chk(tagw("lost_count"), lost_cnt, exp_lc);
`ifdef SI_HEADER_PARSER_V2_STATS_EN
            chk(tagw("stat_rx"), st_rx, n_rx_exp);
            chk(tagw("stat_invalid"), st_inv, n_inv_exp);
            chk(tagw("stat_runt"), st_runt, n_runt_exp);
`endif
        endtask

        task automatic do_reset();
            rst     = 1'b0;
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = '0;
            s_keep  = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk(tagw("rst_s_ready"), s_ready, 1'b0);
            chk(tagw("rst_m_valid"), m_valid, 1'b0);
            chk(tagw("rst_lost"), lost, 1'b0);
            chk(tagw("rst_invalid"), inv, 1'b0);
            chk(tagw("rst_lost_count"), lost_cnt, 32'd0);
`ifdef SI_HEADER_PARSER_V2_STATS_EN
            chk(tagw("rst_stats"), {st_rx, st_inv, st_runt}, 96'd0);
`endif
            @(posedge clk);
            #1;
            rst        = 1'b1;
            base_lost  = n_lost_seen;
            base_inv   = n_inv_seen;
            exp_seq    = '0;
            seq_v      = 1'b0;
            exp_lc     = '0;
            n_lost_exp = 0;
            n_inv_exp  = 0;
            n_rx_exp   = 0;
            n_runt_exp = 0;
        endtask

        task automatic rand_pkt();
            logic [7:0]  pk[$];
            logic [31:0] seq;
            int          r, len, corrupt;
            r = $urandom_range(0, 9);
            corrupt = (r < 3) ? r + 1 : 0;
            if ($urandom_range(0, 7) == 0) len = $urandom_range(1, 27);
            else                           len = $urandom_range(28, 6 * KW);
            r = $urandom_range(0, 9);
            if (!seq_v || r == 9) seq = $urandom;
            else if (r < 6)      seq = exp_seq;
            else if (r < 8)      seq = exp_seq + 32'($urandom_range(1, 5));
            else                 seq = exp_seq - 32'd1;
            build(len, seq, corrupt, pk);
            send(pk, 99, 1'b0);
        endtask

        initial begin
            logic [7:0] pk[$];
            int         seqs[3] = '{7, 8, 11};
            do_reset();

            // 5-word valid packet, first output right after the last header word
            build(5 * KW, 32'd0, 0, pk);
            send(pk, 99, 1'b1);
            drain();

            // gap of two packets: 7, 8, 11
            do_reset();
            foreach (seqs[i]) begin
                build($urandom_range(28, 4 * KW), seqs[i], 0, pk);
                send(pk, 99, 1'b0);
            end
            drain();
            chk(tagw("lost_count_gap"), lost_cnt, 32'd2);

            // bad EtherType followed by a good packet, then a runt and a good packet
            build(4 * KW, 32'd5, 1, pk);
            send(pk, 99, 1'b0);
            build(3 * KW, 32'd12, 0, pk);
            send(pk, 99, 1'b0);
            if (HW > 1) begin
                build((HW - 1) * KW, 32'd13, 0, pk);
                send(pk, 99, 1'b0);
            end
            build(40, 32'd13, 0, pk);
            send(pk, 99, 1'b0);
            drain();

            // wrap-around in order, then a duplicate
            do_reset();
            build(40, 32'hFFFF_FFFF, 0, pk);
            send(pk, 99, 1'b0);
            build(40, 32'd0, 0, pk);
            send(pk, 99, 1'b0);
            drain();
            build(40, 32'd0, 0, pk);
            send(pk, 99, 1'b0);
            drain();

            // random traffic with backpressure and a reset in the middle of a packet
            bp = 1'b1;
            for (int i = 0; i < 40; i++) rand_pkt();
            drain();
            build(3 * KW, 32'd100, 0, pk);
            send(pk, 1, 1'b0);
            do_reset();
            for (int i = 0; i < 20; i++) rand_pkt();
            drain();
            bp   = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(g_w[0].done && g_w[1].done && g_w[2].done) && cyc < 90000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 90000)
            chk("global_timeout", {g_w[0].done, g_w[1].done, g_w[2].done}, 3'b111);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
